atm_transaction: RTL and testbench

ATM_TRANSACTION -- requirements
Module: atm_transaction

---
 rtl/atm_pkg.sv | 26 ++
 rtl/atm_transaction_balance_alu.sv | 45 ++++
 rtl/atm_transaction.sv | 138 +++++++++++++
 tb/tb_atm_transaction.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared ATM definitions: operation codes, FSM state encoding, parameter defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package atm_pkg;

    localparam int BALANCE_WIDTH_DEF = 20;
    localparam int MAX_TRIES_DEF     = 3;

    // Operation select codes as presented on op_sel.
    typedef enum logic [1:0] {
        OP_INQ  = 2'b00,
        OP_DEP  = 2'b01,
        OP_WD   = 2'b10,
        OP_EXIT = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AUTH   = 3'd1,
        ST_MENU   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4,
        ST_LOCKED = 3'd5
    } state_t;

endpackage

// File: rtl/atm_transaction_balance_alu.sv
// Balance ALU: applies inquiry/deposit/withdraw to the working balance.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever the inputs are.
//
// Ports: i_bal working balance, i_amt operand, i_op operation,
//        o_result committed balance, o_ovf deposit overflow, o_borrow withdraw underflow.
module balance_alu
    import atm_pkg::*;
#(
    parameter int W = BALANCE_WIDTH_DEF
) (
    input  logic [W-1:0] i_bal,
    input  logic [W-1:0] i_amt,
    input  op_t          i_op,
    output logic [W-1:0] o_result,
    output logic         o_ovf,
    output logic         o_borrow
);

    // One extra bit so the carry/borrow is visible instead of wrapping.
    logic [W:0] w_sum;
    logic [W:0] w_diff;

    assign w_sum  = {1'b0, i_bal} + {1'b0, i_amt};
    assign w_diff = {1'b0, i_bal} - {1'b0, i_amt};

    always_comb begin
        o_result = i_bal;
        o_ovf    = 1'b0;
        o_borrow = 1'b0;
        case (i_op)
            OP_DEP: begin
                o_ovf = w_sum[W];
                if (!w_sum[W]) o_result = w_sum[W-1:0];
            end
            OP_WD: begin
                // amount == balance gives diff 0 with no borrow: legal.
                o_borrow = w_diff[W];
                if (!w_diff[W]) o_result = w_diff[W-1:0];
            end
            default: o_result = i_bal;
        endcase
    end

endmodule

// File: rtl/atm_transaction.sv
// ATM session controller: card/password authentication, lockout, balance operations.
// Latency: op_valid to op_done is 2 cycles; auth result 2 cycles after pw_valid.
// Backpressure: none; requests outside their legal state are silently dropped.
//
// Ports: clk, rst (async active-low); card_in level; pw_valid/wrong_psw password handshake;
//        balance from card store; op_valid/op_sel/amount request; updated_balance write-back
//        value with op_done strobe; authed/locked status; err_funds/err_ovf reject pulses.
module atm_transaction
    import atm_pkg::*;
#(
    parameter int balance_width = BALANCE_WIDTH_DEF,
    parameter int max_tries     = MAX_TRIES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     card_in,
    input  logic                     pw_valid,
    input  logic                     wrong_psw,
    input  logic [balance_width-1:0] balance,
    input  logic                     op_valid,
    input  logic [1:0]               op_sel,
    input  logic [balance_width-1:0] amount,
    output logic [balance_width-1:0] updated_balance,
    output logic                     op_done,
    output logic                     authed,
    output logic                     err_funds,
    output logic                     err_ovf,
    output logic                     locked
);

    localparam int TRIES_W = $clog2(max_tries + 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [TRIES_W-1:0]       r_tries;
    logic [TRIES_W-1:0]       w_tries_inc;
    logic [balance_width-1:0] r_work_bal;
    op_t                      r_op;
    logic [balance_width-1:0] r_amount;
    logic                     r_err_funds;
    logic                     r_err_ovf;
    op_t                      w_op_sel;
    logic                     w_exit_req;
    logic [balance_width-1:0] w_alu_result;
    logic                     w_alu_ovf;
    logic                     w_alu_borrow;

    assign w_op_sel    = op_t'(op_sel);
    assign w_tries_inc = r_tries + 1'b1;
    assign w_exit_req  = (r_state == ST_MENU) && op_valid && (w_op_sel == OP_EXIT);

    balance_alu #(.W(balance_width)) u_alu (
        .i_bal    (r_work_bal),
        .i_amt    (r_amount),
        .i_op     (r_op),
        .o_result (w_alu_result),
        .o_ovf    (w_alu_ovf),
        .o_borrow (w_alu_borrow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (pw_valid) w_next = ST_AUTH;
            ST_AUTH: begin
                if (!wrong_psw)                                   w_next = ST_MENU;
                else if (w_tries_inc == TRIES_W'(max_tries))      w_next = ST_LOCKED;
                else                                              w_next = ST_IDLE;
            end
            ST_MENU: begin
                if (op_valid) w_next = (w_op_sel == OP_EXIT) ? ST_IDLE : ST_EXEC;
            end
            ST_EXEC:   w_next = ST_DONE;
            ST_DONE:   w_next = ST_MENU;
            ST_LOCKED: w_next = ST_LOCKED;
            default:   w_next = ST_IDLE;
        endcase
        // Card removal overrides everything, including a pending DONE.
        if (!card_in) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tries <= '0;
        end else if (!card_in) begin
            r_tries <= '0;
        end else if (r_state == ST_AUTH) begin
            r_tries <= wrong_psw ? w_tries_inc : '0;
        end else if (w_exit_req) begin
            r_tries <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= OP_INQ;
            r_amount <= '0;
        end else if (card_in && (r_state == ST_MENU) && op_valid && (w_op_sel != OP_EXIT)) begin
            r_op     <= w_op_sel;
            r_amount <= amount;
        end
    end

    // Working balance tracks the card store until authenticated, then is owned here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work_bal <= '0;
        end else if ((r_state == ST_IDLE) || (r_state == ST_AUTH)) begin
            r_work_bal <= balance;
        end else if ((r_state == ST_EXEC) && card_in) begin
            r_work_bal <= w_alu_result;
        end
    end

    // Error flags are captured in EXEC so they line up with op_done in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_funds <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_err_funds <= (r_state == ST_EXEC) && card_in && w_alu_borrow;
            r_err_ovf   <= (r_state == ST_EXEC) && card_in && w_alu_ovf;
        end
    end

    assign updated_balance = r_work_bal;
    assign op_done         = (r_state == ST_DONE) && card_in;
    assign err_funds       = r_err_funds && card_in;
    assign err_ovf         = r_err_ovf && card_in;
    assign authed          = (r_state == ST_MENU) || (r_state == ST_EXEC) || (r_state == ST_DONE);
    assign locked          = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_atm_transaction.sv
// Testbench for atm_transaction: table-driven operations plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_atm_transaction;

    localparam int BW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          card_in = 1'b0;
    logic          pw_valid = 1'b0;
    logic          wrong_psw = 1'b0;
    logic [BW-1:0] balance = '0;
    logic          op_valid = 1'b0;
    logic [1:0]    op_sel = 2'b00;
    logic [BW-1:0] amount = '0;
    logic [BW-1:0] updated_balance;
    logic          op_done;
    logic          authed;
    logic          err_funds;
    logic          err_ovf;
    logic          locked;

    int checks = 0;
    int errors = 0;
    bit in_menu = 1'b0;

    always #5 clk = ~clk;

    atm_transaction #(.balance_width(BW), .max_tries(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .card_in         (card_in),
        .pw_valid        (pw_valid),
        .wrong_psw       (wrong_psw),
        .balance         (balance),
        .op_valid        (op_valid),
        .op_sel          (op_sel),
        .amount          (amount),
        .updated_balance (updated_balance),
        .op_done         (op_done),
        .authed          (authed),
        .err_funds       (err_funds),
        .err_ovf         (err_ovf),
        .locked          (locked)
    );

    typedef struct {
        bit          relogin;
        logic [BW-1:0] bal_in;
        logic [1:0]  op;
        logic [BW-1:0] amt;
        logic [BW-1:0] exp_bal;
        bit          exp_funds;
        bit          exp_ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Card in, present password, answer with wrong_psw in the AUTH cycle.
    task automatic attempt(input logic [BW-1:0] bal, input bit wrong);
        card_in  = 1'b1;
        balance  = bal;
        pw_valid = 1'b1;
        tick();
        pw_valid  = 1'b0;
        wrong_psw = wrong;
        tick();
        wrong_psw = 1'b0;
    endtask

    task automatic exit_menu();
        op_valid = 1'b1;
        op_sel   = 2'b11;
        tick();
        op_valid = 1'b0;
        op_sel   = 2'b00;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [BW-1:0] amt,
                         input logic [BW-1:0] exp_bal, input bit ef, input bit eo);
        op_valid = 1'b1;
        op_sel   = op;
        amount   = amt;
        tick();
        op_valid = 1'b0;
        amount   = '0;
        chk({tag, " op_done early"}, 32'(op_done), 32'd0);
        tick();
        chk({tag, " op_done"}, 32'(op_done), 32'd1);
        chk({tag, " balance"}, 32'(updated_balance), 32'(exp_bal));
        chk({tag, " err_funds"}, 32'(err_funds), 32'(ef));
        chk({tag, " err_ovf"}, 32'(err_ovf), 32'(eo));
        tick();
        chk({tag, " op_done cleared"}, 32'(op_done), 32'd0);
        chk({tag, " authed back in menu"}, 32'(authed), 32'd1);
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{1'b1, 20'd1000,    2'b10, 20'd300,     20'd700,     1'b0, 1'b0};
        vecs[1] = '{1'b0, 20'd0,       2'b00, 20'd0,       20'd700,     1'b0, 1'b0};
        vecs[2] = '{1'b0, 20'd0,       2'b01, 20'd50,      20'd750,     1'b0, 1'b0};
        vecs[3] = '{1'b1, 20'd100,     2'b10, 20'd101,     20'd100,     1'b1, 1'b0};
        vecs[4] = '{1'b0, 20'd0,       2'b10, 20'd100,     20'd0,       1'b0, 1'b0};
        vecs[5] = '{1'b0, 20'd0,       2'b10, 20'd1,       20'd0,       1'b1, 1'b0};
        vecs[6] = '{1'b1, 20'hFFFF0,   2'b01, 20'h20,      20'hFFFF0,   1'b0, 1'b1};
        vecs[7] = '{1'b0, 20'd0,       2'b01, 20'hF,       20'hFFFFF,   1'b0, 1'b0};
        vecs[8] = '{1'b0, 20'd0,       2'b01, 20'h1,       20'hFFFFF,   1'b0, 1'b1};
        vecs[9] = '{1'b0, 20'd0,       2'b10, 20'hFFFFF,   20'd0,       1'b0, 1'b0};

        // Reset state
        #12;
        chk("reset updated_balance", 32'(updated_balance), 32'd0);
        chk("reset authed", 32'(authed), 32'd0);
        chk("reset locked", 32'(locked), 32'd0);
        chk("reset op_done", 32'(op_done), 32'd0);
        chk("reset err_funds", 32'(err_funds), 32'd0);
        chk("reset err_ovf", 32'(err_ovf), 32'd0);
        #5 rst = 1'b1;
        tick();

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].relogin) begin
                if (in_menu) exit_menu();
                attempt(vecs[i].bal_in, 1'b0);
                chk($sformatf("v%0d login authed", i), 32'(authed), 32'd1);
                chk($sformatf("v%0d login balance", i), 32'(updated_balance), 32'(vecs[i].bal_in));
                in_menu = 1'b1;
            end
            do_op($sformatf("v%0d", i), vecs[i].op, vecs[i].amt, vecs[i].exp_bal,
                  vecs[i].exp_funds, vecs[i].exp_ovf);
        end
        exit_menu();
        chk("exit authed", 32'(authed), 32'd0);
        tick();
        card_in = 1'b0;
        tick();

        // Lockout after three wrong passwords
        attempt(20'd42, 1'b1);
        chk("lock try1", 32'(locked), 32'd0);
        attempt(20'd42, 1'b1);
        chk("lock try2", 32'(locked), 32'd0);
        attempt(20'd42, 1'b1);
        chk("lock try3", 32'(locked), 32'd1);
        op_valid = 1'b1;
        op_sel   = 2'b10;
        amount   = 20'd1;
        pw_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        pw_valid = 1'b0;
        tick();
        chk("locked ignores op", 32'(locked), 32'd1);
        chk("locked no op_done", 32'(op_done), 32'd0);
        chk("locked not authed", 32'(authed), 32'd0);
        card_in = 1'b0;
        tick();
        chk("unlock on card out", 32'(locked), 32'd0);

        // Tries cleared by card removal
        attempt(20'd42, 1'b1);
        attempt(20'd42, 1'b1);
        card_in = 1'b0;
        tick();
        attempt(20'd42, 1'b1);
        chk("tries cleared by card out", 32'(locked), 32'd0);

        // Tries cleared by successful login
        attempt(20'd42, 1'b1);
        attempt(20'd42, 1'b0);
        chk("login after two wrong", 32'(authed), 32'd1);
        exit_menu();
        attempt(20'd42, 1'b1);
        chk("tries cleared by success", 32'(locked), 32'd0);
        card_in = 1'b0;
        tick();

        // Card dropped while in EXEC
        attempt(20'd500, 1'b0);
        op_valid = 1'b1;
        op_sel   = 2'b10;
        amount   = 20'd100;
        tick();
        op_valid = 1'b0;
        card_in  = 1'b0;
        balance  = 20'd321;
        tick();
        chk("card drop idle", 32'(authed), 32'd0);
        chk("card drop no op_done", 32'(op_done), 32'd0);
        chk("card drop no err", 32'({err_funds, err_ovf}), 32'd0);
        tick();
        chk("card drop still no op_done", 32'(op_done), 32'd0);
        chk("card drop reload balance", 32'(updated_balance), 32'd321);

        // pw_valid and op_valid together: only the legal one acts
        attempt(20'd200, 1'b0);
        pw_valid = 1'b1;
        do_op("both in menu", 2'b01, 20'd5, 20'd205, 1'b0, 1'b0);
        pw_valid = 1'b0;
        exit_menu();
        balance  = 20'd77;
        pw_valid = 1'b1;
        op_valid = 1'b1;
        op_sel   = 2'b10;
        amount   = 20'd1;
        tick();
        pw_valid = 1'b0;
        op_valid = 1'b0;
        chk("both in idle -> auth", 32'(authed), 32'd0);
        tick();
        chk("both in idle op_done", 32'(op_done), 32'd0);
        chk("both in idle authed", 32'(authed), 32'd1);
        chk("both in idle balance", 32'(updated_balance), 32'd77);

        // Reset asserted mid-operation
        op_valid = 1'b1;
        op_sel   = 2'b10;
        amount   = 20'd7;
        tick();
        op_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async rst balance", 32'(updated_balance), 32'd0);
        chk("async rst authed", 32'(authed), 32'd0);
        chk("async rst op_done", 32'(op_done), 32'd0);
        tick();
        chk("rst held op_done", 32'(op_done), 32'd0);
        chk("rst held err_funds", 32'(err_funds), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("after rst idle", 32'(authed), 32'd0);
        chk("after rst op_done", 32'(op_done), 32'd0);
        chk("after rst reload", 32'(updated_balance), 32'd77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
